// File: rtl/ame_grad_accum.sv
// ame_grad_accum: block accumulator of signed gradient products for the AME
// approximation stage. Each block sums BLK_SAMPLES products A*B into a wide
// accumulator. The result is then presented with a one-cycle done strobe.
// Optional build macro AME_GRAD_ACCUM_ABS_EN: when it is defined, the output
// is the magnitude plus sign. When it is undefined, the output is the raw
// two's-complement sum.
module ame_grad_accum #(
    parameter int unsigned GRAD_DATA_BITS = 16,
    parameter int unsigned COMP_DATA_BITS = 64,
    parameter int unsigned BLK_SAMPLES    = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      comp_init_i,
    input  logic                      comp_valid_i,
    input  logic [GRAD_DATA_BITS-1:0] comp_grad_a_i,
    input  logic [GRAD_DATA_BITS-1:0] comp_grad_b_i,
    output logic                      comp_busy_o,
    output logic                      comp_done_o,
    output logic                      comp_sign_o,
    output logic [COMP_DATA_BITS-1:0] comp_data_o
);

    localparam int unsigned PROD_BITS = 2 * GRAD_DATA_BITS;
    localparam int unsigned CNT_BITS  = $clog2(BLK_SAMPLES);
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(BLK_SAMPLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e                            state_q, state_d;
    logic        [CNT_BITS-1:0]        cnt_q, cnt_d;
    logic signed [PROD_BITS-1:0]       prod_q, prod_d;
    logic                              pv_q, pv_d;
    logic signed [COMP_DATA_BITS-1:0]  acc_q, acc_d;
    logic                              busy_q, busy_d;
    logic                              done_q, done_d;
    logic                              sign_q, sign_d;
    logic        [COMP_DATA_BITS-1:0]  data_q, data_d;

    logic signed [PROD_BITS-1:0]       grad_a_ext;
    logic signed [PROD_BITS-1:0]       grad_b_ext;
    logic        [COMP_DATA_BITS-1:0]  result_data;
    logic                              result_sign;

    // Sign-extend the gradients so the product is formed at full width
    assign grad_a_ext = PROD_BITS'($signed(comp_grad_a_i));
    assign grad_b_ext = PROD_BITS'($signed(comp_grad_b_i));

`ifdef AME_GRAD_ACCUM_ABS_EN
    // Magnitude plus sign. The worst-case sum is far from -2^63, so negation cannot overflow
    assign result_sign = acc_q[COMP_DATA_BITS-1];
    assign result_data = result_sign ? COMP_DATA_BITS'(-acc_q) : COMP_DATA_BITS'(acc_q);
`else
    // Raw two's-complement sum; the sign is simply its MSB
    assign result_sign = acc_q[COMP_DATA_BITS-1];
    assign result_data = COMP_DATA_BITS'(acc_q);
`endif

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, pipeline and output-load decisions
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        pv_d    = 1'b0;
        acc_d   = acc_q;
        done_d  = 1'b0;
        sign_d  = sign_q;
        data_d  = data_q;

        // Stage 2 folds any captured product into the accumulator
        if (pv_q) begin
            acc_d = acc_q + COMP_DATA_BITS'(prod_q);
        end

        unique case (state_q)
            S_IDLE: begin
                if (comp_init_i) begin
                    state_d = S_ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            S_ACCUM: begin
                if (comp_init_i) begin
                    acc_d = '0;
                    cnt_d = '0;
                end else if (comp_valid_i) begin
                    prod_d = grad_a_ext * grad_b_ext;
                    pv_d   = 1'b1;
                    cnt_d  = cnt_q + CNT_BITS'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Leave once stage 1 is empty and acc_q holds the final sum
                if (comp_init_i) begin
                    state_d = S_ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                end else if (!pv_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                data_d  = result_data;
                sign_d  = result_sign;
                state_d = S_IDLE;
                if (comp_init_i) begin
                    state_d = S_ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Busy follows the upcoming state, so it drops on the edge that raises done
    assign busy_d = (state_d != S_IDLE);

    // Datapath and registered outputs
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_d_reset();
        end else begin
            cnt_q  <= cnt_d;
            prod_q <= prod_d;
            pv_q   <= pv_d;
            acc_q  <= acc_d;
            busy_q <= busy_d;
            done_q <= done_d;
            sign_q <= sign_d;
            data_q <= data_d;
        end
    end

    // Reset values of the datapath registers
    task automatic cnt_d_reset();
        cnt_q  <= '0;
        prod_q <= '0;
        pv_q   <= 1'b0;
        acc_q  <= '0;
        busy_q <= 1'b0;
        done_q <= 1'b0;
        sign_q <= 1'b0;
        data_q <= '0;
    endtask

    assign comp_busy_o = busy_q;
    assign comp_done_o = done_q;
    assign comp_sign_o = sign_q;
    assign comp_data_o = data_q;

endmodule
